// File: rtl/dct_pkg.sv
// Shared constants, state encoding, Q12 coefficient table and saturation helper
// for the 8-point DCT/IDCT engines.
package dct_pkg;
  localparam int DW     = 16;
  localparam int AW     = 6;
  localparam int CW     = 14;
  localparam int ACCW   = 32;
  localparam int Q12_RND = 2048;
  localparam int Q12_SH  = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4
  } dct_state_t;

  // Row u, column n at index {u,n}; idct1d reads it as {n,u}.
  localparam logic signed [CW-1:0] DCT_COEF [0:63] = '{
    14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,
    14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009,
    14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892,
    14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703,
    14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,
    14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138,
    14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784,
    14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400
  };

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > 32'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/dct_coef_rom.sv
// Combinational 64-entry Q12 cosine table lookup, indexed by {u,n}.
module dct_coef_rom
  import dct_pkg::*;
(
  input  logic [2:0]           u,
  input  logic [2:0]           n,
  output logic signed [CW-1:0] coef
);
  // table lookup
  always_comb begin
    coef = DCT_COEF[{u, n}];
  end
endmodule

// File: rtl/fdct1d.sv
// Forward 8-point 1-D DCT: eight strided RAM reads, one MAC per coefficient
// term, eight strided writes of saturated Q12-rounded results.
module fdct1d
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [AW-1:0]        rstart,
  input  logic [AW-1:0]        wstart,
  input  logic [AW-1:0]        stride,
  input  logic signed [DW-1:0] q,
  output logic [AW-1:0]        addr,
  output logic                 wren,
  output logic [DW-1:0]        data,
  output logic                 rdy
);
  dct_state_t state_r, state_nxt_s;
  logic [2:0]                k_r, u_r;
  logic [AW-1:0]             stride_r, wptr_r, addr_r;
  logic signed [DW-1:0]      x_r [0:7];
  logic signed [ACCW-1:0]    acc_r, acc_sum_s, rnd_s;
  logic signed [CW-1:0]      coef_s;
  logic signed [DW+CW-1:0]   prod_s;
  logic                      wren_r, rdy_r;
  logic signed [DW-1:0]      data_r;

  dct_coef_rom u_rom (.u(u_r), .n(k_r), .coef(coef_s));

  assign prod_s    = x_r[k_r] * coef_s;
  assign acc_sum_s = acc_r + $signed({{(ACCW-DW-CW){prod_s[DW+CW-1]}}, prod_s});
  assign rnd_s     = (acc_sum_s + ACCW'(Q12_RND)) >>> Q12_SH;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (en) state_nxt_s = ST_READ; else state_nxt_s = ST_IDLE;
      ST_READ:  if (k_r == 3'd7) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_READ;
      ST_DRAIN: state_nxt_s = ST_MAC;
      ST_MAC:   if (k_r == 3'd7) state_nxt_s = ST_WRITE; else state_nxt_s = ST_MAC;
      ST_WRITE: if (u_r == 3'd7) state_nxt_s = ST_IDLE; else state_nxt_s = ST_MAC;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // datapath and registered RAM-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r      <= 3'd0;
      u_r      <= 3'd0;
      stride_r <= '0;
      wptr_r   <= '0;
      addr_r   <= '0;
      acc_r    <= '0;
      wren_r   <= 1'b0;
      data_r   <= '0;
      rdy_r    <= 1'b1;
      for (int i = 0; i < 8; i++) x_r[i] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            stride_r <= stride;
            wptr_r   <= wstart;
            addr_r   <= rstart;
            k_r      <= 3'd0;
            rdy_r    <= 1'b0;
          end
        end
        ST_READ: begin
          // q answers the address presented one cycle earlier
          if (k_r != 3'd0) x_r[k_r - 3'd1] <= q;
          k_r    <= k_r + 3'd1;
          addr_r <= (k_r == 3'd7) ? '0 : addr_r + stride_r;
        end
        ST_DRAIN: begin
          x_r[7] <= q;
          k_r    <= 3'd0;
          u_r    <= 3'd0;
          acc_r  <= '0;
        end
        ST_MAC: begin
          acc_r <= acc_sum_s;
          k_r   <= k_r + 3'd1;
          if (k_r == 3'd7) begin
            wren_r <= 1'b1;
            addr_r <= wptr_r;
            data_r <= sat_dw(rnd_s);
          end
        end
        ST_WRITE: begin
          wren_r <= 1'b0;
          addr_r <= '0;
          data_r <= '0;
          acc_r  <= '0;
          k_r    <= 3'd0;
          wptr_r <= wptr_r + stride_r;
          if (u_r == 3'd7) rdy_r <= 1'b1;
          else             u_r   <= u_r + 3'd1;
        end
        default: begin
          wren_r <= 1'b0;
          rdy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign addr = addr_r;
  assign wren = wren_r;
  assign data = data_r;
  assign rdy  = rdy_r;
endmodule

// File: tb/tb_fdct1d.sv
// Self-checking bench for fdct1d: behavioural RAM, real-valued cosine model,
// randomized and directed transforms compared against the model.
module tb_fdct1d;
  logic        clk = 1'b0;
  logic        reset, en;
  logic [5:0]  rstart, wstart, stride, addr;
  logic [15:0] q, data;
  logic        wren, rdy;

  logic [15:0] ram [0:63];
  int          cyc = 0;
  logic [5:0]  la[$];
  logic [15:0] ld[$];
  int          lc[$];
  int          npass = 0, ntotal = 0;

  fdct1d dut (.clk(clk), .reset(reset), .en(en), .rstart(rstart), .wstart(wstart),
              .stride(stride), .q(q), .addr(addr), .wren(wren), .data(data), .rdy(rdy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM with one-cycle read latency plus a write log
  always @(posedge clk) begin
    q <= ram[addr];
    if (wren) begin
      ram[addr] <= data;
      la.push_back(addr);
      ld.push_back(data);
      lc.push_back(cyc);
    end
  end

  function automatic int coef_ref(int u, int n);
    real cu, v;
    cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 4096.0 * cu / 2.0 * $cos(real'((2 * n + 1) * u) * 3.14159265358979 / 16.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  function automatic void ref_run(input int rs, input int st, output int xo[8]);
    longint acc;
    int     xs[8];
    logic [15:0] w;
    for (int n = 0; n < 8; n++) begin
      w = ram[(rs + n * st) & 63];
      xs[n] = int'($signed(w));
    end
    for (int u = 0; u < 8; u++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) acc += longint'(xs[n]) * longint'(coef_ref(u, n));
      acc = (acc + 64'sd2048) >>> 12;
      xo[u] = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : int'(acc);
    end
  endfunction

  task automatic run(input logic [5:0] rs, input logic [5:0] ws, input logic [5:0] st,
                     output int busy);
    la.delete(); ld.delete(); lc.delete();
    @(negedge clk);
    rstart = rs; wstart = ws; stride = st; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    busy = 0;
    while (rdy !== 1'b1 && busy < 300) begin
      @(posedge clk); #1;
      busy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; rstart = '0; wstart = '0; stride = '0;
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    ntotal++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %0b want 1", rdy); else npass++;
    ntotal++; if (wren !== 1'b0) $display("FAIL reset_wren got %0b want 0", wren); else npass++;
    ntotal++; if (addr !== 6'd0) $display("FAIL reset_addr got %0h want 0", addr); else npass++;
    ntotal++; if (data !== 16'd0) $display("FAIL reset_data got %0h want 0", data); else npass++;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_dc();
    int busy;
    for (int i = 0; i < 8; i++) ram[i] = 16'h0100;
    run(6'h00, 6'h00, 6'h01, busy);
    ntotal++; if (busy != 81) $display("FAIL dc_busy got %0d want 81", busy); else npass++;
    ntotal++; if (ram[0] !== 16'h02D4) $display("FAIL dc_x0 got %0h want 02d4", ram[0]); else npass++;
    for (int i = 1; i < 8; i++) begin
      ntotal++; if (ram[i] !== 16'h0000) $display("FAIL dc_x%0d got %0h want 0", i, ram[i]); else npass++;
    end
  endtask

  task automatic test_impulse();
    int busy, xo[8];
    ram[0] = 16'h1000;
    for (int i = 1; i < 8; i++) ram[i] = 16'h0000;
    ref_run(0, 1, xo);
    run(6'h00, 6'h20, 6'h01, busy);
    ntotal++; if (la.size() != 8) $display("FAIL imp_count got %0d want 8", la.size()); else npass++;
    ntotal++; if (ld[0] !== 16'd1448) $display("FAIL imp_x0 got %0d want 1448", ld[0]); else npass++;
    ntotal++; if (ld[1] !== 16'd2009) $display("FAIL imp_x1 got %0d want 2009", ld[1]); else npass++;
    for (int u = 0; u < 8; u++) begin
      ntotal++;
      if (ld[u] !== 16'(coef_ref(u, 0)) || ld[u] !== 16'(xo[u]))
        $display("FAIL imp_u%0d got %0d want %0d", u, $signed(ld[u]), coef_ref(u, 0));
      else npass++;
    end
    for (int u = 1; u < 8; u++) begin
      ntotal++;
      if (lc[u] - lc[u-1] != 9) $display("FAIL imp_spacing%0d got %0d want 9", u, lc[u] - lc[u-1]);
      else npass++;
    end
  endtask

  task automatic test_saturation();
    int busy, xo[8];
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) ram[i] = (pass == 0) ? 16'h7FFF : 16'h8000;
      ref_run(0, 1, xo);
      run(6'h00, 6'h08, 6'h01, busy);
      ntotal++;
      if (ld[0] !== ((pass == 0) ? 16'h7FFF : 16'h8000))
        $display("FAIL sat%0d_x0 got %0h want %0h", pass, ld[0], (pass == 0) ? 16'h7FFF : 16'h8000);
      else npass++;
      for (int u = 1; u < 8; u++) begin
        ntotal++;
        if (ld[u] !== 16'h0000 || ld[u] !== 16'(xo[u]))
          $display("FAIL sat%0d_x%0d got %0h want 0", pass, u, ld[u]);
        else npass++;
      end
    end
  endtask

  task automatic test_column_wrap();
    int busy, xo[8];
    logic [15:0] first [8];
    logic [15:0] samp [8];
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    for (int n = 0; n < 8; n++) samp[n] = ram[(60 + 8 * n) & 63];
    ref_run(60, 8, xo);
    run(6'h3C, 6'h05, 6'h08, busy);
    for (int u = 0; u < 8; u++) begin
      first[u] = ld[u];
      ntotal++;
      if (la[u] !== 6'((5 + 8 * u) & 63) || ld[u] !== 16'(xo[u]))
        $display("FAIL col_u%0d got %0h@%0h want %0h@%0h", u, ld[u], la[u], 16'(xo[u]), 6'((5 + 8 * u) & 63));
      else npass++;
    end
    for (int n = 0; n < 8; n++) ram[(60 + 8 * n) & 63] = samp[n];
    run(6'h3C, 6'h3C, 6'h08, busy);
    for (int u = 0; u < 8; u++) begin
      ntotal++;
      if (ram[(60 + 8 * u) & 63] !== first[u])
        $display("FAIL inplace_u%0d got %0h want %0h", u, ram[(60 + 8 * u) & 63], first[u]);
      else npass++;
    end
  endtask

  task automatic test_reset_mid();
    int t, busy, xo[8];
    for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
    la.delete(); ld.delete(); lc.delete();
    @(negedge clk);
    rstart = 6'h00; wstart = 6'h10; stride = 6'h01; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    t = 0;
    while (la.size() < 3 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    ntotal++; if (t >= 300) $display("FAIL rmid_timeout got %0d want <300", t); else npass++;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    ntotal++; if (rdy !== 1'b1) $display("FAIL rmid_rdy got %0b want 1", rdy); else npass++;
    ntotal++; if (wren !== 1'b0) $display("FAIL rmid_wren got %0b want 0", wren); else npass++;
    ntotal++; if (addr !== 6'd0) $display("FAIL rmid_addr got %0h want 0", addr); else npass++;
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    ntotal++; if (la.size() != 3) $display("FAIL rmid_writes got %0d want 3", la.size()); else npass++;
    for (int i = 0; i < 8; i++) ram[i] = 16'($urandom);
    ref_run(0, 1, xo);
    run(6'h00, 6'h10, 6'h01, busy);
    ntotal++; if (busy != 81) $display("FAIL rmid_rerun_busy got %0d want 81", busy); else npass++;
    for (int u = 0; u < 8; u++) begin
      ntotal++;
      if (ld[u] !== 16'(xo[u])) $display("FAIL rmid_rerun_u%0d got %0h want %0h", u, ld[u], 16'(xo[u]));
      else npass++;
    end
  endtask

  task automatic test_random();
    int busy, xo[8];
    logic [5:0] rs, ws, st;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
      rs = 6'($urandom); ws = 6'($urandom); st = 6'($urandom);
      ref_run(int'(rs), int'(st), xo);
      run(rs, ws, st, busy);
      ntotal++; if (busy != 81) $display("FAIL rnd%0d_busy got %0d want 81", it, busy); else npass++;
      for (int u = 0; u < 8; u++) begin
        ntotal++;
        if (la[u] !== 6'((int'(ws) + u * int'(st)) & 63) || ld[u] !== 16'(xo[u]))
          $display("FAIL rnd%0d_u%0d got %0h@%0h want %0h@%0h", it, u, ld[u], la[u],
                   16'(xo[u]), 6'((int'(ws) + u * int'(st)) & 63));
        else npass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, xo[8];
    for (int i = 0; i < 16; i++) ram[i] = 16'($urandom_range(0, 4095) - 2048);
    ref_run(0, 1, xo);
    la.delete(); ld.delete(); lc.delete();
    @(negedge clk);
    rstart = 6'h00; wstart = 6'h08; stride = 6'h01; en = 1'b1;
    @(posedge clk); #1;
    t = 0;
    while (rdy !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    ntotal++; if (t != 81) $display("FAIL b2b_first_busy got %0d want 81", t); else npass++;
    @(posedge clk); #1;
    ntotal++; if (rdy !== 1'b0) $display("FAIL b2b_restart got rdy=%0b want 0", rdy); else npass++;
    en = 1'b0;
    t = 0;
    while (rdy !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    ntotal++; if (la.size() != 16) $display("FAIL b2b_writes got %0d want 16", la.size()); else npass++;
    for (int i = 0; i < 16; i++) begin
      ntotal++;
      if (ld[i] !== 16'(xo[i % 8])) $display("FAIL b2b_w%0d got %0h want %0h", i, ld[i], 16'(xo[i % 8]));
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_saturation();
    test_column_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/fdct1d.md
# fdct1d

Forward 8-point 1-D DCT engine for the MPEG2 hardware path, the encoder-side counterpart of `idct1d`. It reads eight signed 16-bit samples from the shared 64-word block RAM at a programmable start address and stride. It computes the orthonormal forward DCT in Q12 fixed point with a single multiply-accumulate unit, then writes eight coefficients back through the same RAM port. Row and column passes of a 2-D FDCT are both done with this block, selected by `rstart`, `wstart` and `stride`.

## Interface
- `DW`, 16: sample and coefficient width (signed).
- `AW`, 6: RAM address width (64-word block).
- `CW`, 14: coefficient ROM width (signed, Q12).
- `ACCW`, 32: accumulator width (signed).
- `clk` input, 1 bit: single clock; all state on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `en` input, 1 bit: start request, sampled only in IDLE.
- `rstart` input, `AW` bits: first read address, latched on start.
- `wstart` input, `AW` bits: first write address, latched on start.
- `stride` input, `AW` bits: address step between elements, latched on start.
- `q` input, `DW` bits: RAM read data, valid one clock after `addr` is presented.
- `addr` output, `AW` bits: RAM address.
- `wren` output, 1 bit: RAM write enable.
- `data` output, `DW` bits: RAM write data.
- `rdy` output, 1 bit: high only in IDLE.

## Operation
- States: IDLE, READ, DRAIN, MAC, WRITE.
- IDLE
  - `rdy`=1; `addr`, `wren` and `data` are 0.
  - `en`=1 latches `rstart`, `wstart` and `stride`, clears k, and moves to READ.
- READ (8 cycles, k=0..7)
  - `addr` = `rstart` + k·`stride`, mod 64 (wraps naturally).
  - `q` is captured into x[k-1] on the following edge.
  - After k=7, moves to DRAIN.
- DRAIN (1 cycle): captures x[7], clears u and acc, and moves to MAC.
- MAC (8 cycles, n=0..7): acc += x[n]·C[u][n], with a signed 16×14 product.
- WRITE (1 cycle)
  - `wren`=1, `addr` = `wstart` + u·`stride` mod 64, `data` = sat16((acc + 2048) >>> 12).
  - acc is cleared. u=7 goes to IDLE; otherwise u++ and back to MAC.
- Coefficient ROM
  - C[u][n] = round_half_away(4096 · c(u)/2 · cos((2n+1)uπ/16)), with c(0)=1/√2 and c(u>0)=1.
  - Example values: C[0][·]=1448, C[1][0]=2009.
  - Odd rows are exactly antisymmetric and even rows exactly symmetric about n=3.5.
- Saturation clamps to [−32768, 32767]. The accumulator never overflows for full-scale inputs.
- All eight samples are read before any write, so in-place operation (`rstart`=`wstart`) is legal.
- `en` outside IDLE is ignored. `en` held high starts a new transform on the cycle after IDLE is entered.
- Reset mid-operation
  - Immediately returns to IDLE and forces the reset values on all outputs.
  - Issues no further writes. Coefficients already written stay in RAM.

## Timing
- Reset values: `addr`=0, `wren`=0, `data`=0, `rdy`=1, state IDLE, acc=0.
- Latency: `en` sampled at edge E0 leads to `rdy`=1 after edge E0+81. Breakdown: 8 READ + 1 DRAIN + 8·(8 MAC + 1 WRITE).
- Write u occurs in cycle E0+9+9u+9, i.e. one `wren` pulse every 9 cycles, 8 pulses total.
- Outputs are registered. `addr` and `wren` change only on clock edges, except asynchronously on reset.
- `q` is don't-care in all states except the cycle following each READ address.

## Structure
- Package `dct_pkg`, shared with `idct1d`:
  - `DW`, `AW`, `CW`, `ACCW`.
  - Q12 rounding constant 2048 and shift 12.
  - `dct_state_t` enum.
  - The 8×8 coefficient table constant. `idct1d` indexes it transposed.
- Sub-module `dct_coef_rom`: combinational 64-entry lookup indexed by {u,n}, reused by `idct1d`.
- One datapath in this block: register file x[0..7], one multiplier, accumulator and saturator.

## Test plan
- DC: eight samples of 0x0100, `rstart`=`wstart`=0, `stride`=1 → RAM[0]=0x02D4 (724), RAM[1..7]=0; `rdy` low for exactly 81 cycles.
- Impulse: x[0]=0x1000, others 0 → X[u]=C[u][0], so X[0]=1448 and X[1]=2009; 8 `wren` pulses spaced 9 cycles apart.
- Saturation: all samples 0x7FFF → X[0]=0x7FFF, X[1..7]=0, with no accumulator wrap. All samples 0x8000 → X[0]=0x8000.
- Column pass with wrap: `rstart`=0x3C, `stride`=8, `wstart`=0x05 → reads 3C,04,0C,…,34 (mod 64); writes 05,0D,…,3D; in-place variant gives identical results.
- Reset mid-operation: assert `reset` during MAC of u=3 → same-cycle `rdy`=1, `wren`=0, `addr`=0; exactly 3 writes recorded; the next `en` runs a full, correct transform.
- Round trip: random 8-sample vectors within ±2048, fdct1d then idct1d → originals recovered within ±1 LSB.
